// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bundle: decode-side control, instruction-memory req/ack port and F/D register outputs.
// master = fetch unit, slave = decode/hazard logic plus instruction memory.
interface fetch_pc_unit_if;
   logic [31:0] npc;
   logic        redirect;
   logic        stall;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic        valid_d;
   logic        exc_adel_d;

   // imem handshake: a fetch completes in any cycle where imem_req and imem_ack are both 1;
   // imem_addr stays stable while imem_req=1 and imem_ack=0, and ack without req is ignored.
   modport master (
      input  npc, redirect, stall, flush, imem_ack, imem_rdata,
      output imem_req, imem_addr, instr_d, pc_d, pc8_d, valid_d, exc_adel_d
   );

   modport slave (
      output npc, redirect, stall, flush, imem_ack, imem_rdata,
      input  imem_req, imem_addr, instr_d, pc_d, pc8_d, valid_d, exc_adel_d
   );
endinterface

// File: rtl/fetch_pc_unit.sv
// F-stage PC, deferred (delay-slot) redirect, one-entry skid buffer and F/D register.
// Optional FETCH_ALIGN_CHECK_EN: misaligned pc_f raises exc_adel_d instead of issuing a read.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic            clk,
   input  logic            reset,
   fetch_pc_unit_if.master bus,
   output logic            state_dbg_o
);
   typedef enum logic {S_FETCH = 1'b0, S_HOLD = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_f_q, pc_f_d;
   logic        pend_valid_q, pend_valid_d;
   logic [31:0] pend_target_q, pend_target_d;
   logic [31:0] skid_instr_q, skid_instr_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic        skid_exc_q, skid_exc_d;
   logic [31:0] fd_instr_q, fd_instr_d;
   logic [31:0] fd_pc_q, fd_pc_d;
   logic [31:0] fd_pc8_q, fd_pc8_d;
   logic        fd_valid_q, fd_valid_d;
   logic        fd_exc_q, fd_exc_d;

   logic        misalign;
   logic        complete;
   logic [31:0] fetch_word;

`ifdef FETCH_ALIGN_CHECK_EN
   assign misalign = (pc_f_q[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif

   // A misaligned fetch completes on its own, without a memory read.
   assign complete   = (state_q == S_FETCH) && (bus.imem_ack || misalign);
   assign fetch_word = misalign ? 32'h0 : bus.imem_rdata;

   assign bus.imem_req   = (state_q == S_FETCH) && !misalign && !reset;
   assign bus.imem_addr  = pc_f_q;
   assign bus.instr_d    = fd_instr_q;
   assign bus.pc_d       = fd_pc_q;
   assign bus.pc8_d      = fd_pc8_q;
   assign bus.valid_d    = fd_valid_q;
   assign bus.exc_adel_d = fd_exc_q;
   assign state_dbg_o    = (state_q == S_HOLD);

   always_comb begin
      state_d       = state_q;
      pc_f_d        = pc_f_q;
      pend_valid_d  = pend_valid_q;
      pend_target_d = pend_target_q;
      skid_instr_d  = skid_instr_q;
      skid_pc_d     = skid_pc_q;
      skid_exc_d    = skid_exc_q;
      fd_instr_d    = fd_instr_q;
      fd_pc_d       = fd_pc_q;
      fd_pc8_d      = fd_pc8_q;
      fd_valid_d    = fd_valid_q;
      fd_exc_d      = fd_exc_q;

      // Redirects take effect only once the delay-slot fetch has completed.
      if (complete) begin
         if (bus.redirect)      pc_f_d = bus.npc;
         else if (pend_valid_q) pc_f_d = pend_target_q;
         else                   pc_f_d = pc_f_q + 32'd4;
         pend_valid_d = 1'b0;
      end else if (bus.redirect) begin
         pend_valid_d  = 1'b1;
         pend_target_d = bus.npc;
      end

      case (state_q)
         S_FETCH: begin
            if (complete) begin
               if (bus.stall) begin
                  skid_instr_d = fetch_word;
                  skid_pc_d    = pc_f_q;
                  skid_exc_d   = misalign;
                  state_d      = S_HOLD;
               end else begin
                  fd_instr_d = fetch_word;
                  fd_pc_d    = pc_f_q;
                  fd_pc8_d   = pc_f_q + 32'd8;
                  fd_valid_d = 1'b1;
                  fd_exc_d   = misalign;
               end
            end else if (!bus.stall) begin
               fd_instr_d = 32'h0;
               fd_pc_d    = 32'h0;
               fd_pc8_d   = 32'h0;
               fd_valid_d = 1'b0;
               fd_exc_d   = 1'b0;
            end
         end
         S_HOLD: begin
            if (!bus.stall) begin
               fd_instr_d = skid_instr_q;
               fd_pc_d    = skid_pc_q;
               fd_pc8_d   = skid_pc_q + 32'd8;
               fd_valid_d = 1'b1;
               fd_exc_d   = skid_exc_q;
               state_d    = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase

      // Flush only overrides the F/D register; fetch state carries on.
      if (bus.flush) begin
         fd_instr_d = 32'h0;
         fd_pc_d    = 32'h0;
         fd_pc8_d   = 32'h0;
         fd_valid_d = 1'b0;
         fd_exc_d   = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_FETCH;
         pc_f_q        <= RESET_PC;
         pend_valid_q  <= 1'b0;
         pend_target_q <= 32'h0;
         skid_instr_q  <= 32'h0;
         skid_pc_q     <= 32'h0;
         skid_exc_q    <= 1'b0;
         fd_instr_q    <= 32'h0;
         fd_pc_q       <= 32'h0;
         fd_pc8_q      <= 32'h0;
         fd_valid_q    <= 1'b0;
         fd_exc_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_f_q        <= pc_f_d;
         pend_valid_q  <= pend_valid_d;
         pend_target_q <= pend_target_d;
         skid_instr_q  <= skid_instr_d;
         skid_pc_q     <= skid_pc_d;
         skid_exc_q    <= skid_exc_d;
         fd_instr_q    <= fd_instr_d;
         fd_pc_q       <= fd_pc_d;
         fd_pc8_q      <= fd_pc8_d;
         fd_valid_q    <= fd_valid_d;
         fd_exc_q      <= fd_exc_d;
      end
   end
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model (PC value, pending-target queue, held-entry queue).
module tb_fetch_pc_unit;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef FETCH_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic        valid;
      logic        exc;
   } fd_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic state_dbg;
   fetch_pc_unit_if bus ();

   fetch_pc_unit #(.RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .state_dbg_o(state_dbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // stimulus settings applied on the next step
   logic        rst_v = 1'b1, ack_v = 1'b0, stall_v = 1'b0, flush_v = 1'b0, redir_v = 1'b0;
   logic [31:0] npc_v = 32'h0, xor_v = 32'h0;

   // reference model
   logic [31:0] m_pc;
   logic [31:0] m_pend[$];
   fd_t         m_fd;
   fd_t         m_held[$];

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
      end
   endfunction

   function automatic bit model_mis();
      return ALIGN && (m_pc[1:0] != 2'b00);
   endfunction

   function automatic bit model_req();
      return (m_held.size() == 0) && !model_mis();
   endfunction

   task automatic model_reset();
      m_pc = RESET_PC;
      m_pend.delete();
      m_held.delete();
      m_fd = '0;
   endtask

   task automatic model_step(input logic ack);
      fd_t rec, bubble;
      bit  mis, done;
      bubble = '0;
      mis  = model_mis();
      done = (m_held.size() == 0) && (mis || ack);
      rec.instr = mis ? 32'h0 : (m_pc ^ xor_v);
      rec.pc    = m_pc;
      rec.pc8   = m_pc + 32'd8;
      rec.valid = 1'b1;
      rec.exc   = mis;
      if (m_held.size() != 0) begin
         if (!stall_v) begin
            rec  = m_held.pop_front();
            m_fd = flush_v ? bubble : rec;
         end else if (flush_v) m_fd = bubble;
      end else if (done) begin
         if (stall_v) begin
            m_held.push_back(rec);
            if (flush_v) m_fd = bubble;
         end else m_fd = flush_v ? bubble : rec;
      end else if (flush_v || !stall_v) m_fd = bubble;
      if (done) begin
         if (redir_v)                 m_pc = npc_v;
         else if (m_pend.size() != 0) m_pc = m_pend[0];
         else                         m_pc = m_pc + 32'd4;
         m_pend.delete();
      end else if (redir_v) begin
         m_pend.delete();
         m_pend.push_back(npc_v);
      end
   endtask

   task automatic compare_all();
      chk("imem_req",   {31'h0, bus.imem_req},   {31'h0, !rst_v && model_req()});
      chk("imem_addr",  bus.imem_addr,           m_pc);
      chk("instr_d",    bus.instr_d,             m_fd.instr);
      chk("pc_d",       bus.pc_d,                m_fd.pc);
      chk("pc8_d",      bus.pc8_d,               m_fd.pc8);
      chk("valid_d",    {31'h0, bus.valid_d},    {31'h0, m_fd.valid});
      chk("exc_adel_d", {31'h0, bus.exc_adel_d}, {31'h0, m_fd.exc});
      chk("state_hold", {31'h0, state_dbg},      {31'h0, m_held.size() != 0});
   endtask

   // one clock: drive at negedge, advance model, compare #1 after the rising edge
   task automatic step();
      @(negedge clk);
      reset          = rst_v;
      bus.stall      = stall_v;
      bus.flush      = flush_v;
      bus.redirect   = redir_v;
      bus.npc        = npc_v;
      bus.imem_ack   = ack_v;
      bus.imem_rdata = ack_v ? (bus.imem_addr ^ xor_v) : 32'hDEAD_BEEF;
      if (rst_v) model_reset();
      else       model_step(ack_v);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      bus.npc = '0; bus.redirect = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0;
      bus.imem_ack = 1'b0; bus.imem_rdata = '0;
      model_reset();

      // reset state
      rst_v = 1'b1; step(); step();
      chk("rst_req",   {31'h0, bus.imem_req}, 32'h0);
      chk("rst_addr",  bus.imem_addr, 32'h3000);
      chk("rst_valid", {31'h0, bus.valid_d}, 32'h0);
      chk("rst_pc_d",  bus.pc_d, 32'h0);

      // streaming with zero-wait memory
      rst_v = 1'b0; ack_v = 1'b1; step();
      chk("s0_pc_d",  bus.pc_d, 32'h3000);
      chk("s0_pc8_d", bus.pc8_d, 32'h3008);
      chk("s0_instr", bus.instr_d, 32'h3000);
      chk("s0_valid", {31'h0, bus.valid_d}, 32'h1);
      chk("s0_addr",  bus.imem_addr, 32'h3004);

      // two wait states on 3004
      ack_v = 1'b0; step();
      chk("w1_addr", bus.imem_addr, 32'h3004);
      step();
      chk("w2_addr", bus.imem_addr, 32'h3004);
      ack_v = 1'b1; step();
      chk("w3_pc_d", bus.pc_d, 32'h3004);
      chk("w3_addr", bus.imem_addr, 32'h3008);

      // early redirect while 3008 awaits ack
      ack_v = 1'b0; redir_v = 1'b1; npc_v = 32'h3100; step();
      chk("er1_addr", bus.imem_addr, 32'h3008);
      redir_v = 1'b0; step();
      chk("er2_addr", bus.imem_addr, 32'h3008);
      ack_v = 1'b1; step();
      chk("er3_pc_d", bus.pc_d, 32'h3008);
      chk("er3_addr", bus.imem_addr, 32'h3100);
      step();
      chk("er4_pc_d", bus.pc_d, 32'h3100);

      // stall on the ack of 3104, held three cycles
      stall_v = 1'b1; step();
      chk("st1_hold", {31'h0, state_dbg}, 32'h1);
      chk("st1_req",  {31'h0, bus.imem_req}, 32'h0);
      chk("st1_pc_d", bus.pc_d, 32'h3100);
      ack_v = 1'b0; step(); step();
      chk("st3_pc_d", bus.pc_d, 32'h3100);
      stall_v = 1'b0; step();
      chk("st4_pc_d", bus.pc_d, 32'h3104);
      chk("st4_addr", bus.imem_addr, 32'h3108);
      chk("st4_req",  {31'h0, bus.imem_req}, 32'h1);

      // flush dominates stall
      flush_v = 1'b1; stall_v = 1'b1; step();
      chk("fl_valid", {31'h0, bus.valid_d}, 32'h0);
      chk("fl_instr", bus.instr_d, 32'h0);
      chk("fl_addr",  bus.imem_addr, 32'h3108);
      flush_v = 1'b0; stall_v = 1'b0;

      // redirect in the completion cycle, then address wrap
      ack_v = 1'b1; redir_v = 1'b1; npc_v = 32'hFFFF_FFFC; step();
      chk("wr1_addr", bus.imem_addr, 32'hFFFF_FFFC);
      redir_v = 1'b0; step();
      chk("wr2_pc_d", bus.pc_d, 32'hFFFF_FFFC);
      chk("wr2_pc8",  bus.pc8_d, 32'h0000_0004);
      chk("wr2_addr", bus.imem_addr, 32'h0);

      // misaligned target
      redir_v = 1'b1; npc_v = 32'h3002; step();
      chk("al1_addr", bus.imem_addr, 32'h3002);
      redir_v = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
      chk("al1_req", {31'h0, bus.imem_req}, 32'h0);
      ack_v = 1'b0; step();
      chk("al2_exc",   {31'h0, bus.exc_adel_d}, 32'h1);
      chk("al2_instr", bus.instr_d, 32'h0);
`else
      ack_v = 1'b1; step();
      chk("al2_exc",   {31'h0, bus.exc_adel_d}, 32'h0);
      chk("al2_instr", bus.instr_d, 32'h3002);
`endif
      chk("al2_pc_d", bus.pc_d, 32'h3002);

      // reset with a request outstanding, late ack right after release
      ack_v = 1'b0; step();
      rst_v = 1'b1; step();
      rst_v = 1'b0; ack_v = 1'b1; step();
      chk("la_pc_d",  bus.pc_d, 32'h3000);
      chk("la_instr", bus.instr_d, 32'h3000);
      chk("la_addr",  bus.imem_addr, 32'h3004);

      // randomized traffic
      xor_v = 32'h5A5A_0000;
      for (int i = 0; i < 3000; i++) begin
         rst_v   = ($urandom_range(0, 399) == 0);
         stall_v = ($urandom_range(0, 3) == 0);
         flush_v = ($urandom_range(0, 9) == 0);
         redir_v = ($urandom_range(0, 6) == 0);
         case ($urandom_range(0, 15))
            0:       npc_v = 32'hFFFF_FFFC;
            1:       npc_v = 32'h3000 + 32'($urandom_range(0, 255)) * 4 + 32'd2;
            default: npc_v = 32'h3000 + 32'($urandom_range(0, 1023)) * 4;
         endcase
         ack_v = !rst_v && model_req() && ($urandom_range(0, 3) != 0);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
